// File: rtl/toy_fetch_unit.sv
// -----------------------------------------------------------------------------
// toy_fetch_unit
//
// Instruction fetch and sequencing unit for the toy accumulator CPU. Owns the
// program counter, fetches one instruction at a time over a req/ack handshake,
// holds it in an instruction register and issues opcode/operand to the decoder
// over a valid/ready handshake. On accept it resolves the next PC for
// JMP (0000), BCC (1010) and BNE (1011) using the flags present in that cycle.
//
// Optional build macro:
//   TOY_FETCH_ILLEGAL_HALT_EN - when defined, a fetched opcode 0111 is never
//   issued; the unit enters a terminal HALT state (halted=1) until rst.
//   When undefined, 0111 is an ordinary sequential opcode and halted is 0.
//
// Ports:
//   clk          single clock, all state on rising edge
//   rst          synchronous active-high reset
//   imem_req     fetch request (asserted in FETCH)
//   imem_addr    fetch address, equals pc
//   imem_ack     instruction data valid this cycle (honoured only in FETCH)
//   imem_rdata   fetched instruction {opcode[11:8], operand[7:0]}
//   instr_valid  opcode/operand valid to decoder (asserted in ISSUE)
//   instr_ready  execute stage accepts (honoured only in ISSUE)
//   opcode       issued opcode
//   operand      issued operand / branch target
//   flag_c       carry flag, sampled in the accept cycle
//   flag_z       zero flag, sampled in the accept cycle
//   pc           address of the currently fetched/held instruction
//   halted       unit stopped on an illegal opcode
//   retired      accepted-instruction count, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module toy_fetch_unit #(
    parameter int IMEM_AW = 8,
    parameter int IMEM_DW = 12
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [IMEM_DW-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [3:0]         opcode,
    output logic [7:0]         operand,
    input  logic               flag_c,
    input  logic               flag_z,
    output logic [IMEM_AW-1:0] pc,
    output logic               halted,
    output logic [15:0]        retired
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IMEM_AW-1:0] pc_r;
    logic [IMEM_DW-1:0] ir_r;
    logic [15:0]        retired_r;

    logic               fetch_done_s;
    logic               accept_s;
    logic               illegal_s;
    logic [IMEM_AW-1:0] pc_inc_s;
    logic [IMEM_AW-1:0] next_pc_s;

    assign fetch_done_s = (state_r == ST_FETCH) && imem_ack;
    assign accept_s     = (state_r == ST_ISSUE) && instr_ready;

`ifdef TOY_FETCH_ILLEGAL_HALT_EN
    // Illegal opcode is judged on the incoming data so it never reaches ISSUE.
    assign illegal_s = (imem_rdata[11:8] == 4'b0111);
`else
    assign illegal_s = 1'b0;
`endif

    assign pc_inc_s = pc_r + 8'd1;

    // Next-PC selection from the held opcode and the flags of the accept cycle.
    always_comb begin
        next_pc_s = pc_inc_s;
        case (ir_r[11:8])
            4'b0000: next_pc_s = ir_r[7:0];
            4'b1010: begin
                if (flag_c == 1'b0) next_pc_s = ir_r[7:0];
                else                next_pc_s = pc_inc_s;
            end
            4'b1011: begin
                if (flag_z == 1'b0) next_pc_s = ir_r[7:0];
                else                next_pc_s = pc_inc_s;
            end
            default: next_pc_s = pc_inc_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = ST_FETCH;
            ST_FETCH: begin
                if (fetch_done_s && illegal_s) state_s = ST_HALT;
                else if (fetch_done_s)         state_s = ST_ISSUE;
                else                           state_s = ST_FETCH;
            end
            ST_ISSUE: begin
                if (accept_s) state_s = ST_FETCH;
                else          state_s = ST_ISSUE;
            end
            ST_HALT:  state_s = ST_HALT;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_r)
            ST_IDLE:  imem_req    = 1'b0;
            ST_FETCH: imem_req    = 1'b1;
            ST_ISSUE: instr_valid = 1'b1;
`ifdef TOY_FETCH_ILLEGAL_HALT_EN
            ST_HALT:  halted      = 1'b1;
`else
            ST_HALT:  halted      = 1'b0;
`endif
            default:  halted      = 1'b0;
        endcase
    end

    // PC, instruction register and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= 8'h00;
            ir_r      <= 12'h000;
            retired_r <= 16'h0000;
        end else begin
            if (fetch_done_s && !illegal_s) begin
                ir_r <= imem_rdata;
            end
            if (accept_s) begin
                pc_r <= next_pc_s;
                if (retired_r != 16'hFFFF) retired_r <= retired_r + 16'd1;
            end
        end
    end

    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign opcode    = ir_r[11:8];
    assign operand   = ir_r[7:0];
    assign retired   = retired_r;

endmodule

// File: tb/tb_toy_fetch_unit.sv
module tb_toy_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [11:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic        flag_c;
    logic        flag_z;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    toy_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc(pc), .halted(halted), .retired(retired)
    );

    typedef struct {
        logic [7:0] pc;
        logic [3:0] op;
        logic [7:0] opd;
    } issue_t;

    issue_t     exp_issue[$];
    logic [7:0] exp_fetch[$];

    logic [11:0] mem       [256];
    int          delay_tab [256];
    int          hold_tab  [256];
    logic        fc_tab    [256];
    logic        fz_tab    [256];

    logic ack_idle;
    logic ready_idle;
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_issue(input logic [7:0] p, input logic [3:0] o, input logic [7:0] d);
        issue_t e;
        e.pc = p; e.op = o; e.opd = d;
        exp_issue.push_back(e);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 12'h3_00; delay_tab[i] = 0; hold_tab[i] = 0;
            fc_tab[i] = 1'b0; fz_tab[i] = 1'b0;
        end
    endtask

    // Memory responder: acks after delay_tab[addr] wait cycles; junk data elsewhere.
    initial begin
        int wait_cnt;
        wait_cnt = 0; imem_ack = 1'b0; imem_rdata = 12'h7FF;
        forever begin
            @(posedge clk); #1;
            if (imem_req) begin
                if (wait_cnt >= delay_tab[imem_addr]) begin
                    imem_ack = 1'b1; imem_rdata = mem[imem_addr];
                end else begin
                    imem_ack = 1'b0; imem_rdata = 12'h7FF; wait_cnt++;
                end
            end else begin
                imem_ack = ack_idle; imem_rdata = 12'h7FF; wait_cnt = 0;
            end
        end
    end

    // Execute-stage responder and flag driver.
    initial begin
        int hcnt;
        hcnt = 0; instr_ready = 1'b0; flag_c = 1'b0; flag_z = 1'b0;
        forever begin
            @(posedge clk); #1;
            flag_c = fc_tab[pc];
            flag_z = fz_tab[pc];
            if (instr_valid) begin
                if (hcnt < hold_tab[pc]) begin instr_ready = 1'b0; hcnt++; end
                else instr_ready = 1'b1;
            end else begin
                instr_ready = ready_idle; hcnt = 0;
            end
        end
    end

    // Monitor: pops scoreboard on fetch/issue handshakes and checks hold stability.
    initial begin
        logic       pend_req, pend_val;
        logic [7:0] p_addr;
        logic [3:0] p_op;
        logic [7:0] p_opd;
        issue_t     e;
        logic [7:0] a;
        pend_req = 1'b0; pend_val = 1'b0; p_addr = 8'h00; p_op = 4'h0; p_opd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_req = 1'b0; pend_val = 1'b0;
            end else begin
                if (pend_req) begin
                    check("req_stable", {31'd0, imem_req}, 32'd1);
                    check("addr_stable", {24'd0, imem_addr}, {24'd0, p_addr});
                end
                if (pend_val) begin
                    check("valid_stable", {31'd0, instr_valid}, 32'd1);
                    check("instr_stable", {20'd0, opcode, operand}, {20'd0, p_op, p_opd});
                end
                if (imem_req && imem_ack) begin
                    if (exp_fetch.size() == 0) begin
                        total++; bad++;
                        $display("FAIL fetch_unexpected: got addr %0h expected none", imem_addr);
                    end else begin
                        a = exp_fetch.pop_front();
                        check("fetch_addr", {24'd0, imem_addr}, {24'd0, a});
                    end
                end
                if (instr_valid && instr_ready) begin
                    if (exp_issue.size() == 0) begin
                        total++; bad++;
                        $display("FAIL issue_unexpected: got op %0h expected none", opcode);
                    end else begin
                        e = exp_issue.pop_front();
                        check("issue_pc", {24'd0, pc}, {24'd0, e.pc});
                        check("issue_opcode", {28'd0, opcode}, {28'd0, e.op});
                        check("issue_operand", {24'd0, operand}, {24'd0, e.opd});
                    end
                end
                pend_req = imem_req && !imem_ack;
                pend_val = instr_valid && !instr_ready;
                p_addr = imem_addr; p_op = opcode; p_opd = operand;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_opcode"}, {28'd0, opcode}, 32'd0);
        check({tag, "_operand"}, {24'd0, operand}, 32'd0);
        check({tag, "_pc"}, {24'd0, pc}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_retired"}, {16'd0, retired}, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", {24'd0, imem_addr}, 32'd0);
    endtask

    task automatic run_until_empty(input int limit);
        int n;
        n = 0;
        while ((exp_issue.size() != 0 || exp_fetch.size() != 0) && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_issue.size() != 0 || exp_fetch.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout: got %0d/%0d pending expected 0/0",
                     exp_issue.size(), exp_fetch.size());
        end
    endtask

    initial begin
        int viol;
        total = 0; bad = 0;
        rst = 1'b1; ack_idle = 1'b1; ready_idle = 1'b1;
        clear_tables();

        // Program 1: sequential, backpressure, branches, wrap.
        mem[8'h00] = 12'h1_05; mem[8'h01] = 12'h2_06; mem[8'h02] = 12'h0_40;
        mem[8'h40] = 12'hA_10; mem[8'h41] = 12'hA_10; mem[8'h10] = 12'hB_20;
        mem[8'h20] = 12'hB_30; mem[8'h21] = 12'h0_FF; mem[8'hFF] = 12'h3_11;
        delay_tab[8'h01] = 3; hold_tab[8'h01] = 4;
        fc_tab[8'h40] = 1'b1; fc_tab[8'h41] = 1'b0;
        fz_tab[8'h10] = 1'b0; fz_tab[8'h20] = 1'b1;
        push_issue(8'h00, 4'h1, 8'h05); push_issue(8'h01, 4'h2, 8'h06);
        push_issue(8'h02, 4'h0, 8'h40); push_issue(8'h40, 4'hA, 8'h10);
        push_issue(8'h41, 4'hA, 8'h10); push_issue(8'h10, 4'hB, 8'h20);
        push_issue(8'h20, 4'hB, 8'h30); push_issue(8'h21, 4'h0, 8'hFF);
        push_issue(8'hFF, 4'h3, 8'h11);
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h10, 8'h20, 8'h21, 8'hFF, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        release_reset();
        run_until_empty(400);
        check("retired_prog1", {16'd0, retired}, 32'd9);

        // Reset with a fetch ack pending at the same edge.
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");

        // Program 2: illegal opcode at 0x03.
        clear_tables();
        mem[8'h00] = 12'h1_01; mem[8'h01] = 12'h1_02; mem[8'h02] = 12'h1_03;
        mem[8'h03] = 12'h7_00; mem[8'h04] = 12'h1_00;
        push_issue(8'h00, 4'h1, 8'h01); push_issue(8'h01, 4'h1, 8'h02);
        push_issue(8'h02, 4'h1, 8'h03);
`ifdef TOY_FETCH_ILLEGAL_HALT_EN
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03};
        release_reset();
        run_until_empty(200);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'h03)
                viol++;
        end
        check("halt_hold_violations", viol, 32'd0);
        check("retired_halt", {16'd0, retired}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("halt_clear");
`else
        push_issue(8'h03, 4'h7, 8'h00);
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        release_reset();
        run_until_empty(200);
        viol = 0;
        check("halted_tied", {31'd0, halted}, 32'd0);
        check("retired_op7", {16'd0, retired}, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("end_reset");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
